// File: rtl/load_align_unit.sv
// load_align_unit: aligns byte/halfword/word loads (splitting word-crossing accesses) for write-back
module load_align_unit #(
    parameter int ALLOW_MISALIGNED = 1,
    parameter int TAG_W            = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_sext,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_req,
    output logic [29:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_split,
    output logic             res_align_err
);

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE} state_t;

    state_t             state_q;
    logic [1:0]         off_q;
    logic [1:0]         size_q;
    logic               sext_q;
    logic               cross_q;
    logic [31:0]        hi_q;
    logic               mem_req_q;
    logic [29:0]        mem_addr_q;
    logic               res_valid_q;
    logic [31:0]        res_data_q;
    logic [TAG_W-1:0]   res_tag_q;
    logic               res_split_q;
    logic               res_align_err_q;

    logic [1:0]         req_off;
    logic [1:0]         req_size_n;
    logic               req_cross;
    logic [31:0]        rot;
    logic [31:0]        mask_hi;
    logic [31:0]        merged;

    // Rotating left by the byte offset brings the addressed byte to bits 31:24.
    function automatic logic [31:0] rotl(input logic [31:0] w, input logic [1:0] o);
        logic [63:0] d;
        d = {w, w} << {o, 3'b000};
        return d[63:32];
    endfunction

    // Result bytes sit at the top of m; right-align them and extend.
    function automatic logic [31:0] extend(input logic [31:0] m, input logic [1:0] sz, input logic sx);
        return sz == 2'b00 ? {{24{sx & m[31]}}, m[31:24]} :
               sz == 2'b01 ? {{16{sx & m[31]}}, m[31:16]} : m;
    endfunction

    assign req_ready     = (state_q == IDLE);
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;
    assign res_tag       = res_tag_q;
    assign res_split     = res_split_q;
    assign res_align_err = res_align_err_q;

    // Request decode plus the rotate-and-merge datapath for the returned words.
    // In the second word, bytes 0.. land right below the first word's bytes after
    // the same rotation, so a single mask on the offset merges them.
    always_comb begin
        req_off    = req_addr[1:0];
        req_size_n = (req_size == 2'b11) ? 2'b10 : req_size;
        req_cross  = (req_size_n == 2'b01 && req_off == 2'd3) || (req_size_n == 2'b10 && req_off != 2'd0);
        rot        = rotl(mem_rdata, off_q);
        mask_hi    = 32'hFFFF_FFFF << {off_q, 3'b000};
        merged     = hi_q | (rot & ~mask_hi);
    end

    // Control FSM with registered memory and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            off_q           <= 2'd0;
            size_q          <= 2'd0;
            sext_q          <= 1'b0;
            cross_q         <= 1'b0;
            hi_q            <= 32'd0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= 30'd0;
            res_valid_q     <= 1'b0;
            res_data_q      <= 32'd0;
            res_tag_q       <= '0;
            res_split_q     <= 1'b0;
            res_align_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        off_q     <= req_off;
                        size_q    <= req_size_n;
                        sext_q    <= req_sext;
                        cross_q   <= req_cross;
                        res_tag_q <= req_tag;
                        if (req_cross && ALLOW_MISALIGNED == 0) begin
                            state_q         <= DONE;
                            res_valid_q     <= 1'b1;
                            res_data_q      <= 32'd0;
                            res_split_q     <= 1'b0;
                            res_align_err_q <= 1'b1;
                        end else begin
                            state_q    <= REQ1;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= req_addr[31:2];
                        end
                    end
                end
                REQ1: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (mem_rvalid) begin
                        if (cross_q) begin
                            hi_q       <= rot & mask_hi;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= mem_addr_q + 30'd1;
                            state_q    <= REQ2;
                        end else begin
                            res_data_q      <= extend(rot, size_q, sext_q);
                            res_valid_q     <= 1'b1;
                            res_split_q     <= 1'b0;
                            res_align_err_q <= 1'b0;
                            state_q         <= DONE;
                        end
                    end
                end
                REQ2: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT2;
                    end
                end
                WAIT2: begin
                    if (mem_rvalid) begin
                        res_data_q      <= extend(merged, size_q, sext_q);
                        res_valid_q     <= 1'b1;
                        res_split_q     <= 1'b1;
                        res_align_err_q <= 1'b0;
                        state_q         <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed checks of load_align_unit against hand-computed results
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        na_req_valid = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_sext = 1'b0;
    logic [4:0]  req_tag = 5'd0;
    logic        res_ready = 1'b0;
    logic        na_res_ready = 1'b0;
    logic        gnt_ok = 1'b1;
    logic        rv_mute = 1'b0;
    logic        stale_rv = 1'b0;

    logic        req_ready, mem_req, mem_gnt, mem_rvalid, res_valid, res_split, res_align_err;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata, res_data;
    logic [4:0]  res_tag;

    logic        na_req_ready, na_mem_req, na_res_valid, na_res_split, na_res_align_err;
    logic [29:0] na_mem_addr;
    logic [31:0] na_res_data;
    logic [4:0]  na_res_tag;

    logic        rv_q = 1'b0;
    logic [31:0] rdata_q = 32'd0;
    logic        na_seen = 1'b0;
    logic [31:0] mem [logic [29:0]];
    logic [29:0] alog [$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    assign mem_gnt    = mem_req & gnt_ok;
    assign mem_rvalid = (rv_q & ~rv_mute) | stale_rv;
    assign mem_rdata  = rdata_q;

    load_align_unit #(.ALLOW_MISALIGNED(1), .TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_sext(req_sext), .req_tag(req_tag),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_split(res_split), .res_align_err(res_align_err)
    );

    load_align_unit #(.ALLOW_MISALIGNED(0), .TAG_W(5)) dut_na (
        .clk(clk), .reset(reset),
        .req_valid(na_req_valid), .req_ready(na_req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_sext(req_sext), .req_tag(req_tag),
        .mem_req(na_mem_req), .mem_addr(na_mem_addr), .mem_gnt(1'b0),
        .mem_rvalid(1'b0), .mem_rdata(mem_rdata),
        .res_valid(na_res_valid), .res_ready(na_res_ready), .res_data(na_res_data),
        .res_tag(na_res_tag), .res_split(na_res_split), .res_align_err(na_res_align_err)
    );

    // Memory responder: data one cycle after each grant; logs granted addresses.
    always @(posedge clk) begin
        rv_q    <= mem_req & mem_gnt;
        rdata_q <= mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
        if (mem_req && mem_gnt) alog.push_back(mem_addr);
        if (na_mem_req) na_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue(input logic na, input logic [31:0] a, input logic [1:0] s, input logic x, input logic [4:0] t);
        req_addr = a;
        req_size = s;
        req_sext = x;
        req_tag  = t;
        if (na) na_req_valid = 1'b1;
        else req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid    = 1'b0;
        na_req_valid = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_res();
        while (!res_valid && cyc < 40) tick();
    endtask

    task automatic finish_res();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", {31'd0, res_valid}, 32'd0);
        check("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    function automatic logic [29:0] alog_at(input int i);
        return (alog.size() > i) ? alog[i] : 30'h2AAAAAAA;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", {2'd0, mem_addr}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_tag", {27'd0, res_tag}, 32'd0);
        check("rst_res_split", {31'd0, res_split}, 32'd0);
        check("rst_res_err", {31'd0, res_align_err}, 32'd0);

        // Aligned word load.
        mem[30'h40] = 32'h11223344;
        alog.delete();
        issue(1'b0, 32'h100, 2'b10, 1'b0, 5'd3);
        check("lw_mem_req_c1", {31'd0, mem_req}, 32'd1);
        wait_res();
        check("lw_latency", cyc, 3);
        check("lw_data", res_data, 32'h11223344);
        check("lw_split", {31'd0, res_split}, 32'd0);
        check("lw_tag", {27'd0, res_tag}, 32'd3);
        check("lw_err", {31'd0, res_align_err}, 32'd0);
        check("lw_addr", {2'd0, alog_at(0)}, 32'h40);
        finish_res();

        // Byte loads, signed and unsigned.
        mem[30'h40] = 32'hAABBCCF0;
        issue(1'b0, 32'h103, 2'b00, 1'b1, 5'd4);
        wait_res();
        check("lb_sext", res_data, 32'hFFFFFFF0);
        finish_res();
        issue(1'b0, 32'h103, 2'b00, 1'b0, 5'd5);
        wait_res();
        check("lb_zext", res_data, 32'h000000F0);
        finish_res();

        // Split halfword.
        mem[30'h80] = 32'h000000AB;
        mem[30'h81] = 32'hCD000000;
        alog.delete();
        issue(1'b0, 32'h203, 2'b01, 1'b1, 5'd6);
        wait_res();
        check("lh_split_latency", cyc, 5);
        check("lh_split_data", res_data, 32'hFFFFABCD);
        check("lh_split_flag", {31'd0, res_split}, 32'd1);
        check("lh_addr0", {2'd0, alog_at(0)}, 32'h80);
        check("lh_addr1", {2'd0, alog_at(1)}, 32'h81);
        finish_res();

        // Split word wrapping at the top of memory.
        mem[30'h3FFFFFFF] = 32'h0000A1B2;
        mem[30'h0] = 32'hC3D40000;
        alog.delete();
        issue(1'b0, 32'hFFFFFFFE, 2'b11, 1'b1, 5'd7);
        wait_res();
        check("lw_wrap_data", res_data, 32'hA1B2C3D4);
        check("lw_wrap_split", {31'd0, res_split}, 32'd1);
        check("lw_wrap_addr0", {2'd0, alog_at(0)}, 32'h3FFFFFFF);
        check("lw_wrap_addr1", {2'd0, alog_at(1)}, 32'h0);
        finish_res();

        // Delayed grant and result backpressure.
        mem[30'hC0] = 32'hDEADBEEF;
        gnt_ok = 1'b0;
        issue(1'b0, 32'h302, 2'b01, 1'b0, 5'd9);
        for (int k = 0; k < 3; k++) begin
            check("bp_mem_req", {31'd0, mem_req}, 32'd1);
            check("bp_mem_addr", {2'd0, mem_addr}, 32'hC0);
            if (k < 2) tick();
        end
        tick();
        gnt_ok = 1'b1;
        wait_res();
        check("bp_latency", cyc, 6);
        for (int k = 0; k < 4; k++) begin
            check("bp_res_valid", {31'd0, res_valid}, 32'd1);
            check("bp_res_data", res_data, 32'h0000BEEF);
            check("bp_res_tag", {27'd0, res_tag}, 32'd9);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        finish_res();

        // Reset while waiting for data, then a stale rvalid.
        rv_mute = 1'b1;
        issue(1'b0, 32'h100, 2'b10, 1'b0, 5'd10);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rv_mute = 1'b0;
        stale_rv = 1'b1;
        tick();
        stale_rv = 1'b0;
        check("rst_w1_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_w1_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_w1_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        tick();
        check("rst_w1_res_valid_late", {31'd0, res_valid}, 32'd0);

        // Misaligned word rejected when splitting is disabled.
        issue(1'b1, 32'h2, 2'b10, 1'b0, 5'd7);
        check("na_res_valid", {31'd0, na_res_valid}, 32'd1);
        check("na_err", {31'd0, na_res_align_err}, 32'd1);
        check("na_data", na_res_data, 32'd0);
        check("na_tag", {27'd0, na_res_tag}, 32'd7);
        check("na_no_mem_req", {31'd0, na_seen | na_mem_req}, 32'd0);
        na_res_ready = 1'b1;
        tick();
        na_res_ready = 1'b0;
        check("na_req_ready_back", {31'd0, na_req_ready}, 32'd1);
        check("na_no_mem_req_end", {31'd0, na_seen}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
